// File: rtl/div_ratio_ctrl_if.sv
// Control/status bundle between the divider controller and the sequencing logic.
// Carries the run request, the ratio-change handshake and the divider status.
interface div_ratio_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             req_valid;
    logic [CNT_W-1:0] req_div;
    logic             req_ready;
    logic             err;
    logic             busy;
    logic             running;
    logic             out;
    logic             period_tick;
    logic [CNT_W-1:0] cur_div;

    modport master (
        output en, req_valid, req_div,
        input  req_ready, err, busy, running, out, period_tick, cur_div
    );

    modport slave (
        input  en, req_valid, req_div,
        output req_ready, err, busy, running, out, period_tick, cur_div
    );
endinterface

// File: rtl/div_ratio_ctrl.sv
// Programmable clock divider with glitch-free ratio changes and clean start/stop.
// Ratio updates and stops only take effect on a period boundary, so out never emits a runt.
module div_ratio_ctrl #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 12
) (
    input  logic              clk,
    input  logic              reset,
    div_ratio_ctrl_if.slave   bus,
    inout  wire               VDD,
    inout  wire               VSS
);
    typedef enum logic {ST_STOP, ST_RUN} state_e;

    localparam logic [CNT_W-1:0] DEF = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_v_q, pend_v_d;
    logic             out_q, out_d;
    logic             err_q, err_d;
    logic             boundary;
    logic             hs;
    logic [CNT_W:0]   half_d;

    // Power pins carry no logic; this dead net only keeps them referenced.
    wire unused_pwr;
    assign unused_pwr = VDD ^ VSS;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_STOP;
            cnt_q    <= '0;
            div_q    <= DEF;
            pend_q   <= DEF;
            pend_v_q <= 1'b0;
            out_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            out_q    <= out_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        err_d    = 1'b0;
        boundary = (cnt_q == div_q - ONE);
        hs       = bus.req_valid & ~pend_v_q;

        case (state_q)
            ST_STOP: begin
                cnt_d = '0;
                if (pend_v_q) begin
                    div_d    = pend_q;
                    pend_v_d = 1'b0;
                end
                if (bus.en) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (boundary) begin
                    cnt_d = '0;
                    if (pend_v_q) begin
                        div_d    = pend_q;
                        pend_v_d = 1'b0;
                    end
                    if (!bus.en) state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: state_d = ST_STOP;
        endcase

        // hs implies pend_v_q=0, so it never collides with an apply above.
        if (hs) begin
            if (bus.req_div >= TWO) begin
                pend_d   = bus.req_div;
                pend_v_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        // High for the first ceil(N/2) counts of the period about to run.
        half_d = ({1'b0, div_d} + (CNT_W+1)'(1)) >> 1;
        out_d  = (state_d == ST_RUN) && ({1'b0, cnt_d} < half_d);
    end

    assign bus.req_ready   = ~pend_v_q;
    assign bus.busy        = pend_v_q;
    assign bus.err         = err_q;
    assign bus.running     = (state_q == ST_RUN);
    assign bus.out         = out_q;
    assign bus.period_tick = (state_q == ST_RUN) && boundary;
    assign bus.cur_div     = div_q;
endmodule

// File: doc/div_ratio_ctrl.md
# div_ratio_ctrl

Run-time controller for the team's fixed-ratio clock dividers (÷9, ÷12, ÷80 family). It generates a divided output from `clk` with a programmable ratio. Ratio change requests arrive over a valid/ready handshake and are applied only at a period boundary, so `out` never produces a runt pulse. The block also stops and starts the divided output cleanly, and reports period ticks and the active ratio to the sequencing logic above it.

## Interface

Parameters:
- CNT_W, 8: width of the ratio and the internal counter; legal ratios are 2..2^CNT_W-1.
- DEFAULT_DIV, 12: ratio loaded on reset; must be ≥2.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
- en  input  1  run request; 1 = divide, 0 = stop at the next period boundary.
- req_valid  input  1  ratio-change request present.
- req_div  input  CNT_W  requested ratio N.
- req_ready  output  1  1 when no request is pending; a handshake completes on req_valid & req_ready.
- err  output  1  one-cycle pulse when an accepted request had req_div < 2.
- busy  output  1  a valid request is pending and not yet applied.
- running  output  1  divider is active.
- out  output  1  divided clock (registered).
- period_tick  output  1  one-cycle pulse on the last cycle of each running period.
- cur_div  output  CNT_W  ratio currently in effect.
- VDD  inout  1  power pin; no logic connection.
- VSS  inout  1  ground pin; no logic connection.

## Operation

- Registers: cnt (0..N-1), div (active N), pend plus pend_v, running, out, err.
- Reset values: cnt=0, div=DEFAULT_DIV, pend_v=0, running=0, out=0, err=0, period_tick=0. Derived outputs after reset: req_ready=1, busy=0, cur_div=DEFAULT_DIV.
- Waveform while running, with cnt=k in a cycle:
  - out = 1 for k < ceil(N/2), else 0. N=12 gives 6 high/6 low; N=9 gives 5 high/4 low; N=80 gives 40/40.
  - cnt wraps N-1→0.
  - period_tick = 1 exactly when cnt = N-1.
- States:
  - STOPPED (running=0, out=0, cnt=0): if en=1, the next cycle enters RUN with cnt=0 and out=1.
  - RUN: if cnt=N-1 and en=0, the next cycle is STOPPED with out=0. If en=1, wrap and continue. en falling mid-period has no effect until that boundary.
- Request handling:
  - Handshake accepted with req_div ≥ 2: load pend, set pend_v; req_ready drops the next cycle.
  - Handshake accepted with req_div < 2: discard the request; err=1 for the following cycle; pend_v is unchanged.
- Apply rules:
  - RUN: at the edge leaving cnt=div-1 with pend_v=1, set div←pend, clear pend_v, and start the new period at cnt=0 under the new ratio. The wrap/stop decision uses the same en rule as above.
  - STOPPED: pend_v=1 applies on the next edge regardless of en. If en=1 on that edge, the divider starts with the new ratio.
- Boundary conditions:
  - A request accepted in the boundary cycle (cnt=div-1) is not applied at that edge; it takes effect at the following boundary.
  - While pend_v=1, req_ready=0; a held req_valid is not accepted until the cycle after pend_v clears.
  - A ratio equal to the current one is still accepted and applied (no-op).
  - reset in any state returns every register to its reset value; any pending request is discarded.

## Timing

- Request acceptance: pend_v and busy are set 1 cycle after the handshake edge.
- Apply latency while running: at most div_old cycles after acceptance, plus 1 if acceptance falls on the boundary cycle.
- Start: out=1 in the first cycle after the en=1 edge seen in STOPPED.
- Stop: out=0 in the cycle after the boundary where en=0.
- Outputs: out, period_tick, err and running come straight from registers or from a compare against registered state; there is no combinational path from inputs to out.
- req_ready = ~pend_v and is combinational from state only.

## Test plan

- Reset, then en=1 with DEFAULT_DIV=12 → out 1 for 6 cycles, 0 for 6, repeating; period_tick every 12th cycle on cnt=11; cur_div=12.
- Running ÷12, request req_div=9 accepted at cnt=3 → current period finishes its 12 cycles, then out runs 5 high/4 low; cur_div=9 from the first cycle of the new period; busy is high from acceptance until the apply edge.
- Request req_div=80 accepted exactly on cnt=11 → one more full ÷12 period, then 40/40 ÷80.
- Request req_div=1 → no pending request; err=1 for exactly one cycle; the divider keeps running ÷12; req_ready stays 1.
- en dropped at cnt=2 of ÷9 → out completes 5 high/4 low, then stays 0 and running=0. A ratio request of 12 issued while stopped applies on the next edge (cur_div=12) with out still 0. Raising en afterwards gives out=1 on the next cycle.
- reset asserted mid-period with a request pending → next cycle: out=0, running=0, busy=0, cur_div=DEFAULT_DIV, req_ready=1.
